// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin Wishbone B4 pipelined arbiter with outstanding cap and watchdog
module wb_arbiter #(
    parameter int NrMasters      = 2,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4,
    parameter int TimeoutCycles  = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NrMasters-1:0]              m_cyc_i,
    input  logic [NrMasters-1:0]              m_stb_i,
    input  logic [NrMasters-1:0]              m_we_i,
    input  logic [NrMasters*AddrWidth-1:0]    m_adr_i,
    input  logic [NrMasters*DataWidth/8-1:0]  m_sel_i,
    input  logic [NrMasters*DataWidth-1:0]    m_dat_i,
    output logic [DataWidth-1:0]              m_dat_o,
    output logic [NrMasters-1:0]              m_ack_o,
    output logic [NrMasters-1:0]              m_err_o,
    output logic [NrMasters-1:0]              m_stall_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [AddrWidth-1:0]              s_adr_o,
    output logic [DataWidth/8-1:0]            s_sel_o,
    output logic [DataWidth-1:0]              s_dat_o,
    input  logic [DataWidth-1:0]              s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_stall_i,
    output logic [NrMasters-1:0]              grant_o,
    output logic                              timeout_o
);

    localparam int SelWidth = DataWidth / 8;
    localparam int IdxW     = (NrMasters > 1) ? $clog2(NrMasters) : 1;
    localparam int OutW     = $clog2(MaxOutstanding + 1);
    localparam int WdW      = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);
    localparam logic [WdW-1:0]  WdLast = WdW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NrMasters - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [OutW-1:0] out_q, out_d;
    logic [WdW-1:0]  wd_q, wd_d;

    logic            busy;
    logic            own_cyc;
    logic            own_stb;
    logic            resp;
    logic            cap;
    logic            wd_fire;
    logic            accept;
    logic            found;
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] cand;
    int              csum;

    assign busy    = (state_q == BUSY);
    assign m_dat_o = s_dat_i;

    // Owner-side request decode, cap and watchdog condition for the current cycle
    always_comb begin
        own_cyc = m_cyc_i[owner_q];
        own_stb = m_stb_i[owner_q];
        resp    = busy & (s_ack_i | s_err_i);
        // A response in the same cycle frees a slot, so the cap only holds without one
        cap     = (out_q == OutMax) & ~resp;
        wd_fire = (TimeoutCycles > 0) && busy && (out_q != '0) && !resp && (wd_q == WdLast);
    end

    // Slave-side forwarding and per-master responses, combinational from the registered owner
    always_comb begin
        s_cyc_o   = busy & own_cyc;
        s_stb_o   = busy & own_stb & ~cap;
        s_we_o    = m_we_i[owner_q];
        s_adr_o   = m_adr_i[owner_q*AddrWidth +: AddrWidth];
        s_sel_o   = m_sel_i[owner_q*SelWidth +: SelWidth];
        s_dat_o   = m_dat_i[owner_q*DataWidth +: DataWidth];
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        grant_o   = '0;
        timeout_o = wd_fire;
        if (state_q != IDLE) begin
            grant_o[owner_q] = 1'b1;
        end
        if (busy) begin
            m_stall_o[owner_q] = s_stall_i | cap;
            m_ack_o[owner_q]   = s_ack_i;
            m_err_o[owner_q]   = s_err_i | wd_fire;
        end
        accept = s_stb_o & ~s_stall_i;
    end

    // Round-robin search starting one past the previous owner
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        csum  = 0;
        for (int k = 1; k <= NrMasters; k++) begin
            csum = int'(last_q) + k;
            if (csum >= NrMasters) begin
                csum = csum - NrMasters;
            end
            cand = IdxW'(csum);
            if (!found && m_cyc_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic: arbitration, outstanding tracking and watchdog
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        out_d   = out_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    owner_d = pick;
                    last_d  = pick;
                    out_d   = '0;
                    wd_d    = '0;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    out_d   = '0;
                    wd_d    = '0;
                end else if (wd_fire) begin
                    state_d = ABORT;
                    out_d   = '0;
                    wd_d    = '0;
                end else begin
                    // A response with nothing outstanding is ignored so the count never wraps
                    if (accept && !(resp && (out_q != '0))) begin
                        out_d = out_q + 1'b1;
                    end else if (!accept && resp && (out_q != '0)) begin
                        out_d = out_q - 1'b1;
                    end
                    if ((TimeoutCycles > 0) && (out_q != '0) && !resp) begin
                        wd_d = wd_q + 1'b1;
                    end else begin
                        wd_d = '0;
                    end
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; master 0 wins the first arbitration after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IdxLast;
            out_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            out_q   <= out_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [63:0] m_adr_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_dat_i;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_stall_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i, s_stall_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(
        .NrMasters(2), .AddrWidth(32), .DataWidth(32),
        .MaxOutstanding(4), .TimeoutCycles(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc_i   = 2'b00;
        m_stb_i   = 2'b00;
        m_we_i    = 2'b00;
        m_adr_i   = 64'h0;
        m_sel_i   = 8'hFF;
        m_dat_i   = 64'h0;
        s_dat_i   = 32'h0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        s_stall_i = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant_o, 2'b00); end
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc_o); end
        checks++; if (s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b expected 0", s_stb_o); end
        checks++; if (m_stall_o !== 2'b11) begin errors++; $display("FAIL reset_stall: got %b expected 11", m_stall_o); end
        checks++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin errors++; $display("FAIL reset_resp: got ack %b err %b expected 00 00", m_ack_o, m_err_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    endtask

    task automatic test_single_master();
        apply_reset();
        m_cyc_i = 2'b01;
        settle();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL single_grant_latency: got %b expected 00", grant_o); end
        step();
        m_stb_i = 2'b01;
        m_adr_i[31:0] = 32'h100;
        settle();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant_o); end
        checks++; if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin errors++; $display("FAIL single_fwd: got cyc %b stb %b expected 1 1", s_cyc_o, s_stb_o); end
        checks++; if (s_adr_o !== 32'h100) begin errors++; $display("FAIL single_adr0: got %h expected %h", s_adr_o, 32'h100); end
        checks++; if (m_stall_o !== 2'b10) begin errors++; $display("FAIL single_stall: got %b expected 10", m_stall_o); end
        step();
        for (int i = 1; i <= 3; i++) begin
            m_stb_i[0]    = (i < 3);
            m_adr_i[31:0] = 32'h100 + 32'(4 * i);
            s_ack_i       = 1'b1;
            s_dat_i       = 32'hA000_0000 + 32'(i);
            settle();
            checks++; if (m_ack_o !== 2'b01) begin errors++; $display("FAIL single_ack%0d: got %b expected 01", i, m_ack_o); end
            checks++; if (m_dat_o !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL single_data%0d: got %h expected %h", i, m_dat_o, 32'hA000_0000 + 32'(i)); end
            checks++; if (m_stall_o[1] !== 1'b1) begin errors++; $display("FAIL single_m1_stall%0d: got %b expected 1", i, m_stall_o[1]); end
            step();
        end
        s_ack_i = 1'b0;
        m_stb_i = 2'b00;
        m_cyc_i = 2'b00;
        step();
        checks++; if (grant_o !== 2'b00 || m_stall_o !== 2'b11) begin errors++; $display("FAIL single_release: got grant %b stall %b expected 00 11", grant_o, m_stall_o); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        m_cyc_i = 2'b11;
        step();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_first: got %b expected 01", grant_o); end
        m_cyc_i = 2'b10;
        settle();
        checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_drop_cyc: got %b expected 0", s_cyc_o); end
        step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_dead_cycle: got %b expected 00", grant_o); end
        step();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL rr_second: got %b expected 10", grant_o); end
        checks++; if (s_cyc_o !== 1'b1 || m_stall_o !== 2'b01) begin errors++; $display("FAIL rr_second_fwd: got cyc %b stall %b expected 1 01", s_cyc_o, m_stall_o); end
        m_cyc_i = 2'b01;
        step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_idle2: got %b expected 00", grant_o); end
        m_cyc_i = 2'b11;
        step();
        checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rr_alternate: got %b expected 01", grant_o); end
        m_cyc_i = 2'b00;
        step();
    endtask

    task automatic test_outstanding_cap();
        apply_reset();
        m_cyc_i = 2'b01;
        step();
        m_stb_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (s_stb_o !== 1'b1 || m_stall_o[0] !== 1'b0) begin errors++; $display("FAIL cap_accept%0d: got stb %b stall %b expected 1 0", i, s_stb_o, m_stall_o[0]); end
            step();
        end
        settle();
        checks++; if (m_stall_o[0] !== 1'b1 || s_stb_o !== 1'b0) begin errors++; $display("FAIL cap_full: got stall %b stb %b expected 1 0", m_stall_o[0], s_stb_o); end
        s_ack_i = 1'b1;
        settle();
        checks++; if (m_stall_o[0] !== 1'b0 || s_stb_o !== 1'b1) begin errors++; $display("FAIL cap_release: got stall %b stb %b expected 0 1", m_stall_o[0], s_stb_o); end
        checks++; if (m_ack_o !== 2'b01) begin errors++; $display("FAIL cap_ack: got %b expected 01", m_ack_o); end
        step();
        s_ack_i = 1'b0;
        settle();
        checks++; if (m_stall_o[0] !== 1'b1) begin errors++; $display("FAIL cap_refull: got %b expected 1", m_stall_o[0]); end
        m_stb_i = 2'b00;
        m_cyc_i = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        apply_reset();
        m_cyc_i = 2'b11;
        step();
        m_stb_i = 2'b01;
        settle();
        step();
        m_stb_i = 2'b00;
        for (int k = 1; k <= 15; k++) begin
            settle();
            checks++; if (timeout_o !== 1'b0 || m_err_o !== 2'b00) begin errors++; $display("FAIL wd_early%0d: got timeout %b err %b expected 0 00", k, timeout_o, m_err_o); end
            step();
        end
        settle();
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b expected 1", timeout_o); end
        checks++; if (m_err_o !== 2'b01) begin errors++; $display("FAIL wd_err: got %b expected 01", m_err_o); end
        step();
        s_ack_i = 1'b1;
        settle();
        checks++; if (m_ack_o !== 2'b00) begin errors++; $display("FAIL wd_late_ack: got %b expected 00", m_ack_o); end
        checks++; if (s_cyc_o !== 1'b0 || timeout_o !== 1'b0 || m_stall_o !== 2'b11) begin errors++; $display("FAIL wd_abort: got cyc %b timeout %b stall %b expected 0 0 11", s_cyc_o, timeout_o, m_stall_o); end
        s_ack_i = 1'b0;
        m_cyc_i = 2'b10;
        step();
        checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL wd_idle: got %b expected 00", grant_o); end
        step();
        checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL wd_next_owner: got %b expected 10", grant_o); end
        m_cyc_i = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_cyc_i = 2'b01;
        step();
        m_stb_i = 2'b01;
        step();
        step();
        m_stb_i = 2'b00;
        rst     = 1'b1;
        s_ack_i = 1'b1;
        step();
        rst     = 1'b0;
        m_cyc_i = 2'b00;
        settle();
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_mid_slave: got grant %b cyc %b stb %b expected 00 0 0", grant_o, s_cyc_o, s_stb_o); end
        checks++; if (m_stall_o !== 2'b11 || m_ack_o !== 2'b00 || m_err_o !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("FAIL rst_mid_master: got stall %b ack %b err %b to %b expected 11 00 00 0", m_stall_o, m_ack_o, m_err_o, timeout_o); end
        s_ack_i = 1'b0;
        m_cyc_i = 2'b10;
        m_adr_i[63:32] = 32'h200;
        step();
        m_stb_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (grant_o !== 2'b10 || s_stb_o !== 1'b1 || s_adr_o !== 32'h200) begin errors++; $display("FAIL rst_mid_m1_%0d: got grant %b stb %b adr %h expected 10 1 200", i, grant_o, s_stb_o, s_adr_o); end
            step();
        end
        settle();
        checks++; if (m_stall_o[1] !== 1'b1) begin errors++; $display("FAIL rst_mid_cap: got %b expected 1", m_stall_o[1]); end
        m_stb_i = 2'b00;
        m_cyc_i = 2'b00;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_master();
        test_round_robin();
        test_outstanding_cap();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
